// File: rtl/dco_pkg.sv
// rtl/dco_pkg.sv - shared types and helpers for the multi-channel NCO
package dco_pkg;

    typedef enum logic {
        MODE_SQUARE = 1'b0,
        MODE_PULSE  = 1'b1
    } mode_e;

    // Width-independent part of a channel's state; the channel embeds it
    // alongside its parameter-sized accumulator and code registers.
    typedef struct packed {
        mode_e mode;
        mode_e shadow_mode;
        logic  pending;
    } chan_ctrl_t;

    function automatic int ch_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/dco_nco_chan.sv
// rtl/dco_nco_chan.sv - one NCO channel: accumulator, shadow code and wrap-aligned apply
module dco_nco_chan
    import dco_pkg::*;
#(
    parameter int CODE_W = 8,
    parameter int ACC_W  = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              ena,
    input  logic              load,
    input  logic [CODE_W-1:0] code_in,
    input  mode_e             mode_in,
    output logic              osc_out,
    output logic              wrap,
    output logic              pending
);

    localparam int SUM_W = ACC_W + 1;

    typedef struct packed {
        logic [ACC_W-1:0]  acc;
        logic [CODE_W-1:0] active_code;
        logic [CODE_W-1:0] shadow_code;
        chan_ctrl_t        ctrl;
    } chan_state_t;

    chan_state_t      st;
    logic [SUM_W-1:0] sum;
    logic             apply;

    assign sum = {1'b0, st.acc} + SUM_W'(st.active_code);

    // A stopped channel has no wrap to wait for, so it takes the shadow at once.
    assign apply = st.ctrl.pending && ((ena && sum[ACC_W]) || (st.active_code == '0));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            st   <= '0;
            wrap <= 1'b0;
        end else begin
            if (ena) begin
                st.acc <= sum[ACC_W-1:0];
                wrap   <= sum[ACC_W];
            end else begin
                st.acc <= '0;
                wrap   <= 1'b0;
            end
            if (apply) begin
                st.active_code  <= st.shadow_code;
                st.ctrl.mode    <= st.ctrl.shadow_mode;
                st.ctrl.pending <= 1'b0;
            end else if (load) begin
                st.shadow_code      <= code_in;
                st.ctrl.shadow_mode <= mode_in;
                st.ctrl.pending     <= 1'b1;
            end
        end
    end

    assign osc_out = (st.ctrl.mode == MODE_PULSE) ? wrap : st.acc[ACC_W-1];
    assign pending = st.ctrl.pending;

endmodule

// File: rtl/dco_nco_multi.sv
// rtl/dco_nco_multi.sv - CHANNELS independent NCOs behind one code-write handshake
module dco_nco_multi
    import dco_pkg::*;
#(
    parameter int  CHANNELS = 2,
    parameter int  CODE_W   = 8,
    parameter int  ACC_W    = 16,
    localparam int CH_W     = ch_w(CHANNELS)
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                ena,
    input  logic                code_valid,
    output logic                code_ready,
    input  logic [CH_W-1:0]     code_ch,
    input  logic [CODE_W-1:0]   code_in,
    input  logic                mode_in,
    output logic [CHANNELS-1:0] osc_out,
    output logic [CHANNELS-1:0] wrap,
    output logic [CHANNELS-1:0] pending,
    output logic                err
);

    localparam int NPAD = 1 << CH_W;

    logic [NPAD-1:0] pending_pad;
    logic            ch_valid;
    logic            accept;

    // Unused index slots read as not-pending, so writes to them are always ready.
    assign pending_pad = NPAD'(pending);
    assign ch_valid    = int'(code_ch) < CHANNELS;
    assign code_ready  = !pending_pad[code_ch];
    assign accept      = code_valid && code_ready;

    for (genvar g = 0; g < CHANNELS; g++) begin : g_chan
        dco_nco_chan #(
            .CODE_W (CODE_W),
            .ACC_W  (ACC_W)
        ) u_chan (
            .clk     (clk),
            .rst_n   (rst_n),
            .ena     (ena),
            .load    (accept && ch_valid && (code_ch == CH_W'(g))),
            .code_in (code_in),
            .mode_in (mode_e'(mode_in)),
            .osc_out (osc_out[g]),
            .wrap    (wrap[g]),
            .pending (pending[g])
        );
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err <= 1'b0;
        end else if (accept && !ch_valid) begin
            err <= 1'b1;
        end
    end

endmodule

// File: tb/tb_dco_nco_multi.sv
// tb/tb_dco_nco_multi.sv - scoreboard bench for dco_nco_multi (3 channels, 8-bit acc)
module tb_dco_nco_multi;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       ena;
    logic       code_valid;
    logic       code_ready;
    logic [1:0] code_ch;
    logic [7:0] code_in;
    logic       mode_in;
    logic [2:0] osc_out;
    logic [2:0] wrap;
    logic [2:0] pending;
    logic       err;

    int checks = 0;
    int errors = 0;

    typedef struct {
        string       name;
        logic [10:0] want;
        logic [10:0] mask;
    } exp_t;

    exp_t exp_q[$];

    dco_nco_multi #(
        .CHANNELS (3),
        .CODE_W   (8),
        .ACC_W    (8)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .ena        (ena),
        .code_valid (code_valid),
        .code_ready (code_ready),
        .code_ch    (code_ch),
        .code_in    (code_in),
        .mode_in    (mode_in),
        .osc_out    (osc_out),
        .wrap       (wrap),
        .pending    (pending),
        .err        (err)
    );

    always #5 clk = ~clk;

    function automatic logic [10:0] observed();
        return {osc_out, wrap, pending, code_ready, err};
    endfunction

    task automatic check(input string nm, input logic [10:0] got, input logic [10:0] want,
                         input logic [10:0] mask);
        checks++;
        if ((got & mask) !== (want & mask)) begin
            errors++;
            $display("FAIL %s got osc/wrap/pend/rdy/err=%b_%b_%b_%b_%b want %b_%b_%b_%b_%b",
                     nm, got[10:8], got[7:5], got[4:2], got[1], got[0],
                     want[10:8], want[7:5], want[4:2], want[1], want[0]);
        end
    endtask

    // Inputs present at the coming rising edge; expectation is the state after it.
    task automatic tk(input string nm, input logic [2:0] o, input logic [2:0] w,
                      input logic [2:0] p, input logic r, input logic e, input logic chk_r);
        exp_t x;
        @(posedge clk);
        x.name = nm;
        x.want = {o, w, p, r, e};
        x.mask = chk_r ? 11'h7FF : 11'h7FD;
        exp_q.push_back(x);
        @(negedge clk);
        #1;
    endtask

    initial begin : monitor
        exp_t x;
        forever begin
            @(negedge clk);
            if (exp_q.size() > 0) begin
                x = exp_q.pop_front();
                check(x.name, observed(), x.want, x.mask);
            end
        end
    end

    initial begin : watchdog
        #200000;
        errors++;
        $display("FAIL watchdog time limit reached");
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    logic t1_o[7] = '{0, 1, 1, 0, 0, 1, 1};
    logic t1_w[7] = '{0, 0, 0, 1, 0, 0, 0};
    logic t2_o[4] = '{0, 1, 1, 0};
    logic t2_w[4] = '{0, 0, 0, 1};
    logic t3_o[8] = '{0, 1, 1, 0, 1, 0, 1, 0};
    logic t3_w[8] = '{0, 0, 0, 1, 0, 1, 0, 1};
    logic t3_p[8] = '{0, 1, 1, 0, 0, 0, 0, 0};
    logic t3_r[8] = '{1, 0, 0, 1, 1, 1, 1, 1};

    initial begin : stim
        logic ev, p1;
        rst_n = 1'b0; ena = 1'b0; code_valid = 1'b0;
        code_ch = 2'd0; code_in = 8'h00; mode_in = 1'b0;
        repeat (2) @(negedge clk);
        #1;
        tk("reset_state", 3'b000, 3'b000, 3'b000, 1'b1, 1'b0, 1'b1);
        rst_n = 1'b1; ena = 1'b1;

        // ch0 code 0x40 square: stopped channel applies one cycle after accept
        code_valid = 1'b1; code_ch = 2'd0; code_in = 8'h40; mode_in = 1'b0;
        tk("wr40_accept", 3'b000, 3'b000, 3'b001, 1'b0, 1'b0, 1'b1);
        code_valid = 1'b0;
        tk("wr40_apply", 3'b000, 3'b000, 3'b000, 1'b1, 1'b0, 1'b1);
        for (int i = 0; i < 7; i++)
            tk("run40", {2'b00, t1_o[i]}, {2'b00, t1_w[i]}, 3'b000, 1'b1, 1'b0, 1'b1);

        // ena low with acc at 0xC0: everything clears and stays clear
        ena = 1'b0;
        for (int i = 0; i < 5; i++)
            tk("ena_off", 3'b000, 3'b000, 3'b000, 1'b1, 1'b0, 1'b1);
        ena = 1'b1;
        for (int i = 0; i < 4; i++)
            tk("ena_restart", {2'b00, t2_o[i]}, {2'b00, t2_w[i]}, 3'b000, 1'b1, 1'b0, 1'b1);

        // ch0 rewritten to 0x80 mid-period: applied at the wrap edge
        code_in = 8'h80;
        for (int i = 0; i < 8; i++) begin
            code_valid = (i == 1);
            tk("retune80", {2'b00, t3_o[i]}, {2'b00, t3_w[i]}, {2'b00, t3_p[i]},
               t3_r[i], 1'b0, 1'b1);
        end
        code_valid = 1'b0;

        // ch1 pulse 0x20 at edge 26, then ch0 rewritten while ch1 applies (edge 27)
        for (int i = 0; i < 19; i++) begin
            if (i == 0) begin
                code_valid = 1'b1; code_ch = 2'd1; code_in = 8'h20; mode_in = 1'b1;
            end else if (i == 1) begin
                code_valid = 1'b1; code_ch = 2'd0; code_in = 8'h80; mode_in = 1'b0;
            end else begin
                code_valid = 1'b0;
            end
            ev = ((26 + i) % 2) == 0;
            p1 = (i == 9) || (i == 17);
            tk("ch1_pulse", {1'b0, p1, ev}, {1'b0, p1, !ev},
               (i == 0) ? 3'b010 : ((i == 1 || i == 2) ? 3'b001 : 3'b000),
               !(i <= 2), 1'b0, 1'b1);
        end
        code_valid = 1'b0;

        // write to channel index 3 (invalid): dropped, err sticky
        code_valid = 1'b1; code_ch = 2'd3; code_in = 8'h55; mode_in = 1'b1;
        tk("bad_ch", 3'b000, 3'b001, 3'b000, 1'b1, 1'b1, 1'b1);
        code_valid = 1'b0; code_ch = 2'd0;
        tk("err_sticky", 3'b001, 3'b000, 3'b000, 1'b1, 1'b1, 1'b1);
        tk("err_sticky", 3'b000, 3'b001, 3'b000, 1'b1, 1'b1, 1'b1);
        tk("err_sticky", 3'b001, 3'b000, 3'b000, 1'b1, 1'b1, 1'b1);
        tk("err_sticky", 3'b000, 3'b001, 3'b000, 1'b1, 1'b1, 1'b1);

        // pending write plus mid-count accumulators, then async reset
        code_valid = 1'b1; code_ch = 2'd0; code_in = 8'h40; mode_in = 1'b0;
        tk("pre_reset", 3'b001, 3'b000, 3'b001, 1'b0, 1'b1, 1'b1);
        code_valid = 1'b0;
        rst_n = 1'b0;
        #1;
        check("async_reset", observed(), {3'b000, 3'b000, 3'b000, 1'b1, 1'b0}, 11'h7FF);
        tk("in_reset", 3'b000, 3'b000, 3'b000, 1'b1, 1'b0, 1'b1);
        rst_n = 1'b1;
        for (int i = 0; i < 4; i++)
            tk("post_reset", 3'b000, 3'b000, 3'b000, 1'b1, 1'b0, 1'b1);

        @(negedge clk);
        #1;
        check("queue_drained", 11'(exp_q.size()), 11'd0, 11'h7FF);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/dco_nco_multi.md
Name: dco_nco_multi

Overview:
- Parametrised, fully synthesisable successor to the single-channel DCO: CHANNELS independent numerically controlled oscillators (phase accumulators).
- Each channel has its own frequency code and output mode.
- Code updates go through a valid/ready handshake into a shadow register. The shadow is applied glitch-free at the channel's next accumulator wrap.
- Sits behind the tt_um top: ui_in/uio_in carry code writes, uo_out carries the channel outputs.

Parameters:
- CHANNELS, 2, number of independent oscillator channels (1..8)
- CODE_W, 8, frequency code width
- ACC_W, 16, phase accumulator width; must be >= CODE_W
- CH_W, $clog2(CHANNELS) (min 1), channel index width (derived, not overridable)

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- ena  in  1  global run enable
- code_valid  in  1  code write request
- code_ready  out  1  write can be accepted for the addressed channel
- code_ch  in  CH_W  target channel of write
- code_in  in  CODE_W  new frequency code
- mode_in  in  1  new output mode: 0 = square, 1 = pulse
- osc_out  out  CHANNELS  per-channel oscillator output
- wrap  out  CHANNELS  one-cycle strobe on accumulator carry-out
- pending  out  CHANNELS  shadow code not yet applied
- err  out  1  sticky: write accepted to channel index >= CHANNELS

Behaviour:
- Reset (async assert, sync release):
  - All accumulators, active codes, shadow codes and modes = 0.
  - pending, wrap, osc_out and err all = 0.
- Handshake:
  - code_ready = !pending[code_ch]; combinational. Forced to 1 when code_ch >= CHANNELS.
  - A write is accepted on a rising edge where code_valid && code_ready.
  - Accept to a valid channel: shadow_code and shadow_mode load; pending[ch] is set.
  - Accept to an invalid channel: the write is dropped and err is set; err clears only on reset.
  - No write can collide with a shadow apply: ready is low while pending.
- Apply rule, per channel, evaluated on the registered state:
  - Apply when pending && (carry_next || active_code == 0).
  - On apply, at that edge: active_code <= shadow_code, mode <= shadow_mode, pending cleared.
  - Consequence: a stopped channel (code 0) picks up a new code 1 cycle after accept.
  - A running channel holds its old code until its wrap edge; the new code takes effect from the following add.
- Accumulator, when ena = 1:
  - {carry_next, acc_next} = acc + zero_ext(active_code), ACC_W+1 bits wide.
  - acc <= acc_next each cycle; wraps modulo 2^ACC_W.
  - wrap[c] <= carry_next (registered).
- Output frequency: f_clk * code / 2^ACC_W.
- Outputs:
  - Square mode: osc_out[c] = acc[ACC_W-1] (register bit).
  - Pulse mode: osc_out[c] = wrap[c].
- ena = 0:
  - Accumulators and wrap clear to 0 on the next edge, so outputs go low.
  - Handshake still works; shadows still load.
  - Apply still occurs for channels with active_code == 0.
- Channels are fully independent; simultaneous wraps and applies on multiple channels are permitted.
- Reset mid-operation discards all pending writes.

Decomposition:
- Shared package dco_pkg holds:
  - The mode enum (MODE_SQUARE = 0, MODE_PULSE = 1).
  - A channel-state struct (acc, active_code, shadow_code, mode, shadow_mode, pending).
- One sub-module, dco_nco_chan, holds one channel's accumulator, shadow and apply logic.
- The top instantiates it with a generate loop and adds the handshake decode and err flag.

Test Plan (CHANNELS=2, CODE_W=8, ACC_W=8 unless noted):
- Reset then write ch0 code 0x40, square, ena=1:
  - pending[0] high for 1 cycle.
  - acc0 sequence 40,80,C0,00,...
  - osc_out[0] 2 high / 2 low, period 4.
  - wrap[0] every 4th cycle.
- Ch0 running at 0x40; write 0x80 mid-period:
  - code_ready low until the wrap edge.
  - Old period completes intact; the next period is 2 cycles.
  - No runt pulse.
- Ch1 pulse mode, code 0x20:
  - osc_out[1] is a 1-cycle high every 8 cycles.
  - Ch0 unaffected, independent of simultaneous writes.
- Write with code_ch index invalid (CHANNELS=3 build, ch=3):
  - ready = 1; write dropped; err = 1 and stays set.
  - All channels unchanged.
- ena dropped for 5 cycles while running:
  - osc_out and wrap are 0 and accumulators read 0.
  - On re-enable, the sequence restarts from 0x40.
- rst_n asserted with pending set and accumulators mid-count:
  - All outputs 0 immediately (async).
  - After release, ready = 1 and no code applies.
